spk_pool_buffer: RTL and testbench
==================================

// Module: spk_pool_buffer
// PURPOSE
//  Downstream stage of the conv dense core. Captures each per-PE-row binary spike map on
//  new_spk_train_ready and applies 2x2 OR-pooling (binary max-pool) over the valid conv region.
//  Writes pooled words into a ping-pong spike RAM indexed by (time_step, out_channel).
//  Hands a full layer's bank to the next layer with a loaded/release handshake.
// PARAMETERS
//  TIME_STEPS         3                 time steps per inference
//  OUT_CHANNELS       16                conv output channels
//  PE_ARRAY_ROW_SIZE  2                 spike maps delivered per event (one per PE row)
//  FRAME_WIDTH        6                 side of incoming spike map (bit p = r*FRAME_WIDTH+c)
//  KERNEL_SIZE        3                 conv kernel side; VALID_WIDTH = FRAME_WIDTH-KERNEL_SIZE+1
//  POOL_WIDTH         VALID_WIDTH/2     pooled map side; VALID_WIDTH must be even (elab $error)
//  DEPTH              TIME_STEPS*OUT_CHANNELS   entries per bank
// PORTS
//  clk                  in   1    clock
//  rst                  in   1    synchronous reset, active-low (rst==0 resets)
//  spk_arr              in   [FRAME_WIDTH**2] x PE_ARRAY_ROW_SIZE   spike maps from conv core
//  new_spk_train_ready  in   1    1-cycle strobe: spk_arr/prev_* valid this cycle
//  prev_time_step       in   $clog2(TIME_STEPS)+1    time step of the strobed maps
//  prev_oc_phase        in   $clog2(OUT_CHANNELS)+1  oc phase of the strobed maps
//  post_syn_RAM_loaded  in   1    1-cycle strobe: upstream layer complete
//  rd_addr              in   $clog2(DEPTH)   consumer read address, ts*OUT_CHANNELS+oc
//  rd_data              out  POOL_WIDTH**2   pooled word of the read bank, 1-cycle latency
//  pool_RAM_loaded      out  1    1-cycle strobe: read bank swapped and ready
//  rd_release           in   1    1-cycle strobe: consumer finished with read bank
//  busy                 out  1    capture/write or swap pending
//  err_overflow         out  1    sticky: strobe arrived while unable to accept
// BEHAVIOUR
//  Reset (rst==0): FSM->IDLE; wr_bank=0; rd bank marked free; rd_data=0; pool_RAM_loaded=0;
//   busy=0; err_overflow=0. RAM contents are not cleared.
//  Capture: in IDLE, strobe -> register all PE_ARRAY_ROW_SIZE maps plus tags; next state WRITE.
//  Pooling: out bit (i,j) = OR of in bits (2i+a)*FRAME_WIDTH+(2j+b), for a,b in {0,1} and i,j<POOL_WIDTH.
//   Rows/cols >= VALID_WIDTH are ignored.
//  WRITE: one RAM write per cycle, row r = 0..PE_ARRAY_ROW_SIZE-1.
//   addr = ts*OUT_CHANNELS + oc_phase*PE_ARRAY_ROW_SIZE + r; bank = wr_bank.
//   After the last row -> IDLE, or -> SWAP if a layer-done is latched.
//  Layer done: post_syn_RAM_loaded is latched in any state. It arrives in the same cycle
//   as the final spike strobe; the final capture is written before the swap.
//  SWAP: if rd bank free -> toggle wr_bank, mark rd bank owned, pulse pool_RAM_loaded 1 cycle, -> IDLE.
//   Otherwise hold in SWAP (busy=1) until rd_release.
//  rd_release: marks rd bank free; ignored when already free.
//  Overflow: a strobe in WRITE or SWAP is dropped and sets err_overflow (sticky until reset).
//   The same applies to tags out of range (ts>=TIME_STEPS or oc_phase*ROWS>=OUT_CHANNELS).
//  Read: rd_data <= bank[~wr_bank][rd_addr] every cycle, regardless of ownership.
//  busy = (state != IDLE) | layer-done latched.
//  Reset mid-WRITE abandons the partial writes; earlier RAM words persist.
// STRUCTURE
//  snn_pkg: pool_state_e {IDLE, WRITE, SWAP}; width helper functions (clog2-based tag/addr widths).
//  Sub-module spk_or_pool: combinational, one FRAME_WIDTH**2 map -> POOL_WIDTH**2 word.
//   Instantiated PE_ARRAY_ROW_SIZE times.
//  RAM: two simple-dual-port arrays of DEPTH x POOL_WIDTH**2, inferred as distributed RAM.
// TESTING
//  1. Map with only bit 7 set (r1,c1), ts=0, oc=0 -> after 1 strobe + 2 cycles,
//     bank0[0]=4'b0001 and bank0[1]=0.
//  2. Full 3 ts x 8 phases stream, post_syn_RAM_loaded with last strobe ->
//     exactly one pool_RAM_loaded pulse after the 2nd write.
//     rd_addr 47 returns the last pooled word one cycle later.
//  3. Bits in col 4/5 or row 4/5 only (outside VALID_WIDTH=4) -> pooled word 0.
//  4. Second layer completes without rd_release -> held in SWAP, busy=1, no pulse.
//     rd_release -> pulse the next cycle and wr_bank toggles.
//  5. Strobe 1 cycle after a strobe (during WRITE) -> err_overflow=1, RAM at the
//     dropped address is unchanged.
//  6. rst=0 asserted mid-WRITE -> all outputs reach reset values on the next edge.
//     A new strobe after release is accepted normally.

Source files
------------

// File: rtl/spk_pool_buffer_pkg.sv
// Shared types and width helpers for the spike pooling buffer.
package spk_pool_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SWAP
    } pool_state_e;

    // Tag ports carry one extra bit so out-of-range tags can be detected.
    function automatic int tag_w(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spk_pool_buffer_or_pool.sv
// 2x2 binary max-pool (OR) of one spike map over its valid conv region.
module spk_or_pool #(
    parameter int FRAME_WIDTH = 6,
    parameter int POOL_WIDTH  = 2
) (
    input  logic [FRAME_WIDTH*FRAME_WIDTH-1:0] spk_map,
    output logic [POOL_WIDTH*POOL_WIDTH-1:0]   pooled
);

    // Bits beyond the valid region are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^spk_map;

    always_comb begin
        pooled = '0;
        for (int i = 0; i < POOL_WIDTH; i++) begin
            for (int j = 0; j < POOL_WIDTH; j++) begin
                pooled[i*POOL_WIDTH+j] = spk_map[(2*i)*FRAME_WIDTH + 2*j]
                                       | spk_map[(2*i)*FRAME_WIDTH + 2*j+1]
                                       | spk_map[(2*i+1)*FRAME_WIDTH + 2*j]
                                       | spk_map[(2*i+1)*FRAME_WIDTH + 2*j+1];
            end
        end
    end

endmodule

// File: rtl/spk_pool_buffer.sv
// Captures per-PE-row spike maps, OR-pools them into a ping-pong RAM and hands
// completed banks to the next layer with a loaded/release handshake.
module spk_pool_buffer
    import spk_pool_buffer_pkg::*;
#(
    parameter int TIME_STEPS        = 3,
    parameter int OUT_CHANNELS      = 16,
    parameter int PE_ARRAY_ROW_SIZE = 2,
    parameter int FRAME_WIDTH       = 6,
    parameter int KERNEL_SIZE       = 3,
    parameter int VALID_WIDTH       = FRAME_WIDTH - KERNEL_SIZE + 1,
    parameter int POOL_WIDTH        = VALID_WIDTH / 2,
    parameter int DEPTH             = TIME_STEPS * OUT_CHANNELS
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [PE_ARRAY_ROW_SIZE-1:0][FRAME_WIDTH*FRAME_WIDTH-1:0] spk_arr,
    input  logic                                                 new_spk_train_ready,
    input  logic [$clog2(TIME_STEPS):0]                          prev_time_step,
    input  logic [$clog2(OUT_CHANNELS):0]                        prev_oc_phase,
    input  logic                                                 post_syn_RAM_loaded,
    input  logic [$clog2(DEPTH)-1:0]                             rd_addr,
    output logic [POOL_WIDTH*POOL_WIDTH-1:0]                     rd_data,
    output logic                                                 pool_RAM_loaded,
    input  logic                                                 rd_release,
    output logic                                                 busy,
    output logic                                                 err_overflow
);

    localparam int ROWS   = PE_ARRAY_ROW_SIZE;
    localparam int MAP_W  = FRAME_WIDTH * FRAME_WIDTH;
    localparam int WORD_W = POOL_WIDTH * POOL_WIDTH;
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int ROW_W  = addr_w(ROWS);

    if ((VALID_WIDTH % 2) != 0) begin : g_bad_width
        $error("spk_pool_buffer: VALID_WIDTH must be even");
    end

    pool_state_e state, state_d;

    logic [ROWS-1:0][MAP_W-1:0]  map_q;
    logic [ROWS-1:0][WORD_W-1:0] pooled;
    logic [ADDR_W-1:0]           base_q;
    logic [ROW_W-1:0]            row_q;
    logic                        wr_bank;
    logic                        rd_owned;
    logic                        done_q;

    logic tag_ok, capture, drop, last_row, rd_free, we, swap_fire;

    for (genvar r = 0; r < ROWS; r++) begin : g_pool
        spk_or_pool #(
            .FRAME_WIDTH (FRAME_WIDTH),
            .POOL_WIDTH  (POOL_WIDTH)
        ) u_pool (
            .spk_map (map_q[r]),
            .pooled  (pooled[r])
        );
    end

    assign tag_ok   = (int'(prev_time_step) < TIME_STEPS)
                    && (int'(prev_oc_phase) * ROWS < OUT_CHANNELS);
    assign capture  = new_spk_train_ready && tag_ok && (state == IDLE);
    assign drop     = new_spk_train_ready && !capture;
    assign last_row = (row_q == ROW_W'(ROWS - 1));
    // A release in the same cycle frees the read bank immediately.
    assign rd_free  = !rd_owned || rd_release;
    assign busy     = (state != IDLE) || done_q;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d   = state;
        we        = 1'b0;
        swap_fire = 1'b0;
        case (state)
            IDLE: begin
                if (capture)     state_d = WRITE;
                else if (done_q) state_d = SWAP;
            end
            WRITE: begin
                we = 1'b1;
                if (last_row) state_d = (done_q || post_syn_RAM_loaded) ? SWAP : IDLE;
            end
            SWAP: begin
                if (rd_free) begin
                    swap_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            map_q           <= '0;
            base_q          <= '0;
            row_q           <= '0;
            wr_bank         <= 1'b0;
            rd_owned        <= 1'b0;
            done_q          <= 1'b0;
            pool_RAM_loaded <= 1'b0;
            err_overflow    <= 1'b0;
        end else begin
            if (capture) begin
                map_q  <= spk_arr;
                base_q <= ADDR_W'(int'(prev_time_step) * OUT_CHANNELS
                                + int'(prev_oc_phase) * ROWS);
                row_q  <= '0;
            end else if (state == WRITE) begin
                row_q <= row_q + ROW_W'(1);
            end
            done_q          <= (done_q && !swap_fire) || post_syn_RAM_loaded;
            rd_owned        <= swap_fire || (rd_owned && !rd_release);
            pool_RAM_loaded <= swap_fire;
            if (swap_fire) wr_bank <= ~wr_bank;
            if (drop)      err_overflow <= 1'b1;
        end
    end

    // Ping-pong banks; contents survive reset.
    logic [WORD_W-1:0] bank0 [DEPTH];
    logic [WORD_W-1:0] bank1 [DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] rd_word;

    assign wr_addr = base_q + ADDR_W'(row_q);

    always_ff @(posedge clk) begin
        if (we && rst && (int'(wr_addr) < DEPTH)) begin
            if (wr_bank) bank1[wr_addr] <= pooled[row_q];
            else         bank0[wr_addr] <= pooled[row_q];
        end
    end

    always_comb begin
        rd_word = '0;
        if (int'(rd_addr) < DEPTH) rd_word = wr_bank ? bank0[rd_addr] : bank1[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst) rd_data <= '0;
        else      rd_data <= rd_word;
    end

endmodule

// File: tb/tb_spk_pool_buffer.sv
// Directed self-checking bench for spk_pool_buffer.
module tb_spk_pool_buffer;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0][35:0]  spk_arr;
    logic              new_spk_train_ready;
    logic [2:0]        prev_time_step;
    logic [4:0]        prev_oc_phase;
    logic              post_syn_RAM_loaded;
    logic [5:0]        rd_addr;
    logic [3:0]        rd_data;
    logic              pool_RAM_loaded;
    logic              rd_release;
    logic              busy;
    logic              err_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spk_pool_buffer dut (
        .clk                 (clk),
        .rst                 (rst),
        .spk_arr             (spk_arr),
        .new_spk_train_ready (new_spk_train_ready),
        .prev_time_step      (prev_time_step),
        .prev_oc_phase       (prev_oc_phase),
        .post_syn_RAM_loaded (post_syn_RAM_loaded),
        .rd_addr             (rd_addr),
        .rd_data             (rd_data),
        .pool_RAM_loaded     (pool_RAM_loaded),
        .rd_release          (rd_release),
        .busy                (busy),
        .err_overflow        (err_overflow)
    );

    // One input bit per pooling cell, at a different 2x2 offset in each cell.
    function automatic logic [35:0] build_map(input logic [3:0] w);
        logic [35:0] m;
        m = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (w[i*2+j]) m[(2*i+j)*6 + 2*j+i] = 1'b1;
        return m;
    endfunction

    function automatic logic [35:0] outside_map();
        logic [35:0] m;
        m = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                if (r >= 4 || c >= 4) m[r*6+c] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] w1(input int a);
        return 4'((a * 5 + 3) % 16);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int ts, input int oc, input logic [35:0] m0,
                          input logic [35:0] m1, input logic done);
        spk_arr[0]          = m0;
        spk_arr[1]          = m1;
        prev_time_step      = 3'(ts);
        prev_oc_phase       = 5'(oc);
        new_spk_train_ready = 1'b1;
        post_syn_RAM_loaded = done;
        tick();
        new_spk_train_ready = 1'b0;
        post_syn_RAM_loaded = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; spk_arr = '0; new_spk_train_ready = 1'b0; prev_time_step = '0;
        prev_oc_phase = '0; post_syn_RAM_loaded = 1'b0; rd_addr = '0; rd_release = 1'b0;
        tick(); tick();
        checks++; if (rd_data !== 4'h0) begin errors++; $display("FAIL reset_rd_data: got %h exp 0", rd_data); end
        checks++; if (pool_RAM_loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %b exp 0", pool_RAM_loaded); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_overflow); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [35:0] m;
        m = '0; m[7] = 1'b1;
        strobe(0, 0, m, 36'h0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", busy); end
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b exp 0", busy); end
        checks++; if (dut.bank0[0] !== 4'b0001) begin errors++; $display("FAIL single_word0: got %b exp 0001", dut.bank0[0]); end
        checks++; if (dut.bank0[1] !== 4'b0000) begin errors++; $display("FAIL single_word1: got %b exp 0000", dut.bank0[1]); end
    endtask

    task automatic test_valid_region();
        strobe(0, 1, outside_map(), {36{1'b1}}, 1'b0);
        tick(); tick();
        checks++; if (dut.bank0[2] !== 4'h0) begin errors++; $display("FAIL outside_region: got %h exp 0", dut.bank0[2]); end
        checks++; if (dut.bank0[3] !== 4'hf) begin errors++; $display("FAIL full_map: got %h exp f", dut.bank0[3]); end
    endtask

    task automatic test_overflow();
        strobe(1, 0, build_map(4'h5), build_map(4'ha), 1'b0);
        strobe(0, 1, {36{1'b1}}, {36{1'b1}}, 1'b0);
        tick();
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", err_overflow); end
        checks++; if (dut.bank0[2] !== 4'h0) begin errors++; $display("FAIL ovf_dropped_addr: got %h exp 0", dut.bank0[2]); end
        checks++; if (dut.bank0[16] !== 4'h5) begin errors++; $display("FAIL ovf_kept_row0: got %h exp 5", dut.bank0[16]); end
        checks++; if (dut.bank0[17] !== 4'ha) begin errors++; $display("FAIL ovf_kept_row1: got %h exp a", dut.bank0[17]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_idle: got %b exp 0", busy); end
    endtask

    task automatic test_full_layer();
        int early, late, a0;
        early = 0; late = 0;
        for (int k = 0; k < 24; k++) begin
            a0 = (k / 8) * 16 + (k % 8) * 2;
            strobe(k / 8, k % 8, build_map(w1(a0)) | outside_map(),
                   build_map(w1(a0 + 1)) | outside_map(), k == 23);
            if (pool_RAM_loaded) early++;
            tick(); if (pool_RAM_loaded) early++;
            tick(); if (pool_RAM_loaded) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL layer_early_pulse: got %0d exp 0", early); end
        tick();
        checks++; if (pool_RAM_loaded !== 1'b1) begin errors++; $display("FAIL layer_pulse: got %b exp 1", pool_RAM_loaded); end
        for (int c = 0; c < 5; c++) begin tick(); if (pool_RAM_loaded) late++; end
        checks++; if (late !== 0) begin errors++; $display("FAIL layer_single_pulse: extra %0d exp 0", late); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL layer_busy: got %b exp 0", busy); end
        for (int n = 0; n < 4; n++) begin
            int a;
            a = (n == 0) ? 47 : (n == 1) ? 0 : (n == 2) ? 17 : 30;
            rd_addr = 6'(a);
            tick();
            checks++;
            if (rd_data !== w1(a)) begin errors++; $display("FAIL layer_read[%0d]: got %h exp %h", a, rd_data, w1(a)); end
        end
    endtask

    task automatic test_swap_hold();
        int pulses, idle_cnt;
        pulses = 0; idle_cnt = 0;
        strobe(0, 0, build_map(~w1(0)), build_map(~w1(1)), 1'b0);
        tick(); tick();
        strobe(2, 7, build_map(~w1(46)), build_map(~w1(47)), 1'b1);
        rd_addr = 6'd47;
        tick(); tick();
        for (int c = 0; c < 8; c++) begin
            tick();
            if (pool_RAM_loaded) pulses++;
            if (!busy) idle_cnt++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL hold_no_pulse: got %0d exp 0", pulses); end
        checks++; if (idle_cnt !== 0) begin errors++; $display("FAIL hold_busy: idle cycles %0d exp 0", idle_cnt); end
        checks++; if (rd_data !== w1(47)) begin errors++; $display("FAIL hold_old_bank: got %h exp %h", rd_data, w1(47)); end
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        checks++; if (pool_RAM_loaded !== 1'b1) begin errors++; $display("FAIL release_pulse: got %b exp 1", pool_RAM_loaded); end
        tick();
        checks++; if (pool_RAM_loaded !== 1'b0) begin errors++; $display("FAIL release_pulse_end: got %b exp 0", pool_RAM_loaded); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b exp 0", busy); end
        checks++; if (rd_data !== ~w1(47)) begin errors++; $display("FAIL new_bank_47: got %h exp %h", rd_data, ~w1(47)); end
        rd_addr = 6'd0;
        tick();
        checks++; if (rd_data !== ~w1(0)) begin errors++; $display("FAIL new_bank_0: got %h exp %h", rd_data, ~w1(0)); end
        rd_addr = 6'd47;
        tick();
    endtask

    task automatic test_reset_mid();
        strobe(0, 0, build_map(4'h9), build_map(4'h6), 1'b0);
        tick();
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b exp 0", busy); end
        checks++; if (pool_RAM_loaded !== 1'b0) begin errors++; $display("FAIL mid_rst_loaded: got %b exp 0", pool_RAM_loaded); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b exp 0", err_overflow); end
        checks++; if (rd_data !== 4'h0) begin errors++; $display("FAIL mid_rst_rd_data: got %h exp 0", rd_data); end
        checks++; if (dut.bank0[0] !== 4'h9) begin errors++; $display("FAIL mid_rst_row0: got %h exp 9", dut.bank0[0]); end
        checks++; if (dut.bank0[1] !== w1(1)) begin errors++; $display("FAIL mid_rst_abandoned: got %h exp %h", dut.bank0[1], w1(1)); end
        rst = 1'b1;
        tick();
        strobe(1, 2, build_map(4'h5), build_map(4'h6), 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL post_rst_accept: got %b exp 1", busy); end
        tick(); tick();
        checks++; if (dut.bank0[20] !== 4'h5) begin errors++; $display("FAIL post_rst_row0: got %h exp 5", dut.bank0[20]); end
        checks++; if (dut.bank0[21] !== 4'h6) begin errors++; $display("FAIL post_rst_row1: got %h exp 6", dut.bank0[21]); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL post_rst_err: got %b exp 0", err_overflow); end
        strobe(3, 0, {36{1'b1}}, {36{1'b1}}, 1'b0);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL bad_ts_err: got %b exp 1", err_overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_ts_busy: got %b exp 0", busy); end
        rst = 1'b0; tick(); rst = 1'b1; tick();
        strobe(0, 8, {36{1'b1}}, {36{1'b1}}, 1'b0);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL bad_oc_err: got %b exp 1", err_overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_oc_busy: got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_valid_region();
        test_overflow();
        test_full_layer();
        test_swap_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
